// File: rtl/iir_coeff_loader.sv
// Shadow/active coefficient bank for the iir8 MACC chain: writes fill the shadow bank,
// and a commit copies it into the active bank on the next sync. Optional readback: IIR_COEFF_READBACK_EN.
module iir_coeff_loader #(
  parameter int NSTAGES    = 8,
  parameter int COEFF_BITS = 18,
  parameter int ADDR_BITS  = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_BITS-1:0]          wr_addr,
  input  logic [COEFF_BITS-1:0]         wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic                          commit,
  input  logic                          sync,
  output logic [NSTAGES*COEFF_BITS-1:0] coeff1_out,
  output logic [NSTAGES*COEFF_BITS-1:0] coeff2_out,
  output logic                          armed,
  output logic                          update_done,
  output logic                          addr_err,
  input  logic                          err_clr,
  output logic [1:0]                    state_dbg
`ifdef IIR_COEFF_READBACK_EN
  ,
  input  logic [ADDR_BITS-1:0]          rd_addr,
  input  logic                          rd_bank,
  output logic [COEFF_BITS-1:0]         rd_data
`endif
);

  localparam int NWORDS = 2 * NSTAGES;
  localparam int IDX_BITS = $clog2(NWORDS);
  localparam logic [ADDR_BITS:0] NWORDS_EXT = (ADDR_BITS+1)'(NWORDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_APPLY = 2'd2
  } state_t;

  state_t                state;
  logic [COEFF_BITS-1:0] shadow [NWORDS];
  logic [COEFF_BITS-1:0] active [NWORDS];
  logic                  wr_fire;
  logic                  wr_in_range;

  // A write transfers on any edge where wr_valid && wr_ready; the writer holds
  // wr_addr/wr_data stable until then. wr_ready only rises in IDLE.
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_in_range = ({1'b0, wr_addr} < NWORDS_EXT);
  assign state_dbg   = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      wr_ready    <= 1'b0;
      armed       <= 1'b0;
      update_done <= 1'b0;
      for (int i = 0; i < NWORDS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      update_done <= 1'b0;
      // Same-cycle write and commit: the write lands first and joins the commit.
      if (wr_fire && wr_in_range) begin
        shadow[wr_addr[IDX_BITS-1:0]] <= wr_data;
      end
      case (state)
        S_IDLE: begin
          if (commit) begin
            state    <= S_ARMED;
            wr_ready <= 1'b0;
            armed    <= 1'b1;
          end else begin
            wr_ready <= 1'b1;
          end
        end
        S_ARMED: begin
          if (sync) begin
            state <= S_APPLY;
            armed <= 1'b0;
          end
        end
        S_APPLY: begin
          for (int i = 0; i < NWORDS; i++) begin
            active[i] <= shadow[i];
          end
          update_done <= 1'b1;
          wr_ready    <= 1'b1;
          state       <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          wr_ready <= 1'b0;
          armed    <= 1'b0;
        end
      endcase
    end
  end

  // A fresh bad write outranks a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_err <= 1'b0;
    end else if (wr_fire && !wr_in_range) begin
      addr_err <= 1'b1;
    end else if (err_clr) begin
      addr_err <= 1'b0;
    end
  end

  for (genvar k = 0; k < NSTAGES; k++) begin : g_pack
    assign coeff1_out[k*COEFF_BITS +: COEFF_BITS] = active[2*k];
    assign coeff2_out[k*COEFF_BITS +: COEFF_BITS] = active[2*k+1];
  end

`ifdef IIR_COEFF_READBACK_EN
  logic rd_in_range;
  assign rd_in_range = ({1'b0, rd_addr} < NWORDS_EXT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (!rd_in_range) begin
      rd_data <= '0;
    end else if (rd_bank) begin
      rd_data <= active[rd_addr[IDX_BITS-1:0]];
    end else begin
      rd_data <= shadow[rd_addr[IDX_BITS-1:0]];
    end
  end
`endif

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Bench for iir_coeff_loader: directed vector table, hand-written corner sequences,
// and random traffic checked against a bank-level reference model.
module tb_iir_coeff_loader;

  localparam int NS = 8;
  localparam int CB = 18;
  localparam int AB = 5;
  localparam int OW = NS * CB;

  logic          clk;
  logic          rst;
  logic [AB-1:0] wr_addr;
  logic [CB-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic          commit;
  logic          sync;
  logic [OW-1:0] coeff1_out;
  logic [OW-1:0] coeff2_out;
  logic          armed;
  logic          update_done;
  logic          addr_err;
  logic          err_clr;
  logic [1:0]    state_dbg;
`ifdef IIR_COEFF_READBACK_EN
  logic [AB-1:0] rd_addr;
  logic          rd_bank;
  logic [CB-1:0] rd_data;
  initial begin
    rd_addr = '0;
    rd_bank = 1'b0;
  end
`endif

  iir_coeff_loader #(.NSTAGES(NS), .COEFF_BITS(CB), .ADDR_BITS(AB)) dut (
    .clk(clk),
    .rst(rst),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .commit(commit),
    .sync(sync),
    .coeff1_out(coeff1_out),
    .coeff2_out(coeff2_out),
    .armed(armed),
    .update_done(update_done),
    .addr_err(addr_err),
    .err_clr(err_clr),
    .state_dbg(state_dbg)
`ifdef IIR_COEFF_READBACK_EN
    ,
    .rd_addr(rd_addr),
    .rd_bank(rd_bank),
    .rd_data(rd_data)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int          checks;
  int          errors;
  logic [CB-1:0] m_shadow [2*NS];
  logic [CB-1:0] m_active [2*NS];
  int          m_mode;     // 0 waiting for writes/commit, 1 commit pending, 2 copy this cycle
  bit          m_ready;
  bit          m_upd;
  bit          m_err;
  logic [2*OW-1:0] exp_q[$];

  function automatic logic [OW-1:0] model_c1();
    logic [OW-1:0] r;
    for (int k = 0; k < NS; k++) r[k*CB +: CB] = m_active[2*k];
    return r;
  endfunction

  function automatic logic [OW-1:0] model_c2();
    logic [OW-1:0] r;
    for (int k = 0; k < NS; k++) r[k*CB +: CB] = m_active[2*k+1];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2*NS; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_mode  = 0;
    m_ready = 1'b0;
    m_upd   = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_edge();
    bit acc;
    int idx;
    acc = wr_valid && m_ready;
    idx = int'(wr_addr);
    if (acc && idx < 2*NS) m_shadow[idx] = wr_data;
    if (acc && idx >= 2*NS) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    m_upd = 1'b0;
    if (m_mode == 2) begin
      for (int i = 0; i < 2*NS; i++) m_active[i] = m_shadow[i];
      m_upd  = 1'b1;
      m_mode = 0;
      exp_q.push_back({model_c1(), model_c2()});
    end else if (m_mode == 1) begin
      if (sync) m_mode = 2;
    end else begin
      if (commit) m_mode = 1;
    end
    m_ready = (m_mode == 0);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [2*OW-1:0] e;
    chk("wr_ready", OW'(wr_ready), OW'(m_ready));
    chk("armed", OW'(armed), OW'(m_mode == 1));
    chk("update_done", OW'(update_done), OW'(m_upd));
    chk("addr_err", OW'(addr_err), OW'(m_err));
    chk("coeff1_out", coeff1_out, model_c1());
    chk("coeff2_out", coeff2_out, model_c2());
    if (update_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow got update_done=1 want no update at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("sb_c1", coeff1_out, e[2*OW-1:OW]);
        chk("sb_c2", coeff2_out, e[OW-1:0]);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [AB-1:0] a, input logic [CB-1:0] d,
                       input logic c, input logic s, input logic e);
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
    commit   = c;
    sync     = s;
    err_clr  = e;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    model_reset();
    #2;
    chk("rst_wr_ready", OW'(wr_ready), OW'(0));
    chk("rst_armed", OW'(armed), OW'(0));
    chk("rst_coeff1", coeff1_out, '0);
    chk("rst_coeff2", coeff2_out, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          v;
    logic [AB-1:0] a;
    logic [CB-1:0] d;
    logic          c;
    logic          s;
    logic          e;
    logic          x_ready;
    logic          x_armed;
    logic          x_upd;
    logic          x_err;
    logic [CB-1:0] x_c1s0;
    logic [CB-1:0] x_c2s0;
    logic [CB-1:0] x_c2s7;
  } vec_t;

  vec_t tbl [11];

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    idle();

    tbl[0]  = '{1'b1, 5'd0,  18'h04000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'h0,     18'h0,     18'h0};
    tbl[1]  = '{1'b1, 5'd1,  18'h3C000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'h0,     18'h0,     18'h0};
    tbl[2]  = '{1'b0, 5'd0,  18'h0,     1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'h0,     18'h0,     18'h0};
    tbl[3]  = '{1'b0, 5'd0,  18'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'h0,     18'h0,     18'h0};
    tbl[4]  = '{1'b0, 5'd0,  18'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'h0,     18'h0,     18'h0};
    tbl[5]  = '{1'b0, 5'd0,  18'h0,     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h0,     18'h0,     18'h0};
    tbl[6]  = '{1'b0, 5'd0,  18'h0,     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 18'h04000, 18'h3C000, 18'h0};
    tbl[7]  = '{1'b0, 5'd0,  18'h0,     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'h04000, 18'h3C000, 18'h0};
    tbl[8]  = '{1'b1, 5'd15, 18'h01234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'h04000, 18'h3C000, 18'h0};
    tbl[9]  = '{1'b0, 5'd0,  18'h0,     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h04000, 18'h3C000, 18'h0};
    tbl[10] = '{1'b0, 5'd0,  18'h0,     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 18'h04000, 18'h3C000, 18'h01234};

    do_reset();

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].c, tbl[i].s, tbl[i].e);
      step();
      chk($sformatf("tbl%0d_ready", i), OW'(wr_ready), OW'(tbl[i].x_ready));
      chk($sformatf("tbl%0d_armed", i), OW'(armed), OW'(tbl[i].x_armed));
      chk($sformatf("tbl%0d_upd", i), OW'(update_done), OW'(tbl[i].x_upd));
      chk($sformatf("tbl%0d_err", i), OW'(addr_err), OW'(tbl[i].x_err));
      chk($sformatf("tbl%0d_c1s0", i), OW'(coeff1_out[CB-1:0]), OW'(tbl[i].x_c1s0));
      chk($sformatf("tbl%0d_c2s0", i), OW'(coeff2_out[CB-1:0]), OW'(tbl[i].x_c2s0));
      chk($sformatf("tbl%0d_c2s7", i), OW'(coeff2_out[7*CB +: CB]), OW'(tbl[i].x_c2s7));
    end
    idle();

    // Writes stall while a commit is pending and complete once back in IDLE.
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd2, 18'h00FFF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_ready", OW'(wr_ready), OW'(0));
    end
    sync = 1'b1;
    step();
    sync = 1'b0;
    step();
    chk("stall_back_ready", OW'(wr_ready), OW'(1));
    step();
    idle();
    chk("stall_c1s1_held", OW'(coeff1_out[CB +: CB]), OW'(0));
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    step();
    idle();
    step();
    chk("stall_c1s1_new", OW'(coeff1_out[CB +: CB]), OW'(18'h00FFF));

    // Out-of-range writes and the sticky error flag.
    drive(1'b1, 5'd20, 18'h3FFFF, 1'b0, 1'b0, 1'b0);
    step();
    chk("bad_err_set", OW'(addr_err), OW'(1));
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    step();
    chk("bad_err_clr", OW'(addr_err), OW'(0));
    drive(1'b1, 5'd20, 18'h2AAAA, 1'b0, 1'b0, 1'b1);
    step();
    chk("bad_err_wins", OW'(addr_err), OW'(1));
    idle();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    step();
    idle();
    step();
    chk("bad_no_bank_change", OW'(coeff1_out[CB +: CB]), OW'(18'h00FFF));

    // Reset while a commit is pending drops it and clears both banks at once.
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step();
    idle();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_armed", OW'(armed), OW'(0));
    chk("arst_coeff1", coeff1_out, '0);
    chk("arst_coeff2", coeff2_out, '0);
    chk("arst_ready", OW'(wr_ready), OW'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step();
    idle();

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      drive(1'($urandom_range(0, 1)), AB'($urandom_range(0, 19)), CB'($urandom),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 7) == 0));
      step();
    end
    idle();
    for (int i = 0; i < 4; i++) step();

    chk("sb_drained", OW'(exp_q.size()), OW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iir_coeff_loader.md
Name: iir_coeff_loader

Overview:
Writer side of the coefficient inputs of the second-order MACC stages in the iir8 chain. It accepts 18-bit Q4.14 coefficient words over a valid/ready write port into a shadow bank. On commit it waits for a pipeline-safe sync strobe, then copies the whole bank into the active registers atomically. The active registers drive coeff1_in/coeff2_in of every stage, so a coefficient set never changes mid-frame.

Parameters:
NSTAGES, 8, number of MACC stages served; each stage takes one coeff1 and one coeff2.
COEFF_BITS, 18, coefficient width (Q4.14, matches DSP B port).
ADDR_BITS, 5, write address width; must satisfy 2^ADDR_BITS >= 2*NSTAGES.

Ports:
clk  in  1  clock.
rst  in  1  reset; asynchronous, active-high.
wr_addr  in  ADDR_BITS  coefficient index; even = coeff1 of stage addr>>1, odd = coeff2 of stage addr>>1.
wr_data  in  COEFF_BITS  coefficient word.
wr_valid  in  1  write request.
wr_ready  out  1  write accepted when wr_valid&wr_ready.
commit  in  1  request atomic update of active set from shadow.
sync  in  1  pipeline-safe boundary strobe from the filter datapath.
coeff1_out  out  NSTAGES*COEFF_BITS  active coeff1, stage k at [k*COEFF_BITS +: COEFF_BITS].
coeff2_out  out  NSTAGES*COEFF_BITS  active coeff2, same packing.
armed  out  1  commit pending, waiting for sync.
update_done  out  1  one-cycle pulse when the active set changes.
addr_err  out  1  sticky; set by an accepted write with wr_addr >= 2*NSTAGES.
err_clr  in  1  clears addr_err.

Behaviour:
- Reset (async assert, deassert on clk): shadow and active banks = 0 (the MACC then passes add_in unchanged); wr_ready=0 while rst is high; armed=0; update_done=0; addr_err=0; FSM=IDLE.
- FSM states:
  - IDLE: wr_ready=1. An accepted write updates shadow[wr_addr] at the next edge. commit=1 -> ARMED. If commit and an accepted write occur in the same cycle, the write lands in shadow and is included in the commit. sync is ignored in IDLE.
  - ARMED: wr_ready=0 (writes stall, no data loss); armed=1; commit is ignored. sync=1 -> APPLY. sync asserted in the same cycle commit is accepted does not count; the first qualifying sync is the one seen in ARMED.
  - APPLY (1 cycle): active <= shadow for all 2*NSTAGES words at this edge; update_done=1 during the same cycle coeff outputs show new values; next state IDLE; wr_ready=0.
- Latency: commit seen at edge N -> armed high from N+1; sync high at edge M in ARMED -> APPLY from M+1; new coefficients and update_done valid from M+2.
- Commit with no intervening writes still arms and applies; result is identical to the current active set, and update_done still pulses.
- Invalid address (>= 2*NSTAGES) is accepted (handshake completes), data is dropped, and addr_err is set. err_clr has priority over a same-cycle set only when no new error occurs that cycle; a new error wins.
- Shadow persists across applies; partial rewrites are allowed.
- All outputs are registered; no combinational path from any input to coeff*_out.
- Reset mid-ARMED or mid-APPLY: both banks clear immediately; the pending commit is lost.

Optional Feature:
IIR_COEFF_READBACK_EN: adds ports rd_addr (in, ADDR_BITS), rd_bank (in, 1: 0=shadow, 1=active) and rd_data (out, COEFF_BITS). rd_data is registered, giving 1-cycle latency, and reads 0 for an out-of-range address. Readback is available in every state. Without the macro, these ports are not present and no read mux is built.

Test Plan:
- Reset, then sample -> all coeff outputs 0, wr_ready=1, armed=0, addr_err=0.
- Write addr0=0x04000, addr1=0x3C000 (-1.0), commit, sync 3 cycles later -> coeff1_out[17:0]=0x04000 and coeff2_out[17:0]=0x3C000 exactly 2 cycles after the sync edge, one update_done pulse; before that, outputs stay 0.
- Commit with write to addr15=0x01234 in the same cycle, then sync -> stage 7 coeff2=0x01234 after apply.
- While ARMED, hold wr_valid with addr2=0x00FFF for 10 cycles -> wr_ready=0 throughout; write completes the cycle after returning to IDLE; active stage1 coeff1 unchanged until the next commit/sync.
- Write addr=20 (NSTAGES=8) -> handshake completes, addr_err=1, no bank change; err_clr -> addr_err=0; simultaneous err_clr and a new bad write -> addr_err stays 1.
- Assert rst while ARMED -> armed=0 and outputs 0 asynchronously; a later sync causes no update_done.
